// File: rtl/store_formatter.sv
// MEM-stage store formatter: lane-replicates register data, builds byte enables and word-aligns the
// address, behind a registered output plus one-entry skid buffer. Alignment faults: STORE_ALIGN_CHECK_EN.
module store_formatter #(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_size,
  output logic               o_mem_valid,
  input  logic               i_mem_ready,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic [3:0]         o_mem_be,
  output logic               o_fault,
  output logic [NB_ADDR-1:0] o_fault_addr,
  output logic [1:0]         o_dbg_state
);

  // Handshake: a request transfers on a rising edge where i_valid && o_ready && !i_flush; a memory
  // write transfers where o_mem_valid && i_mem_ready. Both ready signals come from registers only.

  localparam int NB_ENT = NB_ADDR + NB_DATA + 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ENT-1:0]   out_q, out_d;
  logic [NB_ENT-1:0]   skid_q, skid_d;
  logic [NB_ADDR-1:0]  fmt_addr;
  logic [NB_DATA-1:0]  fmt_wdata;
  logic [3:0]          fmt_be;
  logic [NB_ENT-1:0]   fmt_ent;
  logic                misaligned;
  logic                accept;
  logic                take;

  always_comb begin
    fmt_addr   = {i_addr[NB_ADDR-1:2], 2'b00};
    fmt_wdata  = i_data;
    fmt_be     = 4'b1111;
    misaligned = 1'b0;
    case (i_size)
      2'b00: begin
        fmt_wdata = {4{i_data[7:0]}};
        fmt_be    = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{i_data[15:0]}};
        fmt_be    = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;  // word, and reserved size treated as word
    endcase
`ifdef STORE_ALIGN_CHECK_EN
    misaligned = ((i_size == 2'b01) && i_addr[0]) ||
                 ((i_size == 2'b10) && (i_addr[1:0] != 2'b00)) ||
                 (i_size == 2'b11);
`endif
    fmt_ent = {fmt_addr, fmt_wdata, fmt_be};
  end

  assign o_ready = (state_q != ST_TWO);
  assign accept  = i_valid && o_ready && !i_flush;
  // A faulting request is consumed but never enters the buffers.
  assign take    = accept && !misaligned;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (take) begin
            out_d   = fmt_ent;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (take && i_mem_ready) begin
            out_d = fmt_ent;
          end else if (take) begin
            skid_d  = fmt_ent;
            state_d = ST_TWO;
          end else if (i_mem_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (i_mem_ready) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign o_mem_valid = (state_q != ST_EMPTY);
  assign o_mem_addr  = out_q[NB_ENT-1 -: NB_ADDR];
  assign o_mem_wdata = out_q[NB_DATA+3 -: NB_DATA];
  assign o_mem_be    = out_q[3:0];
  assign o_dbg_state = state_q;

`ifdef STORE_ALIGN_CHECK_EN
  logic               fault_q, fault_d;
  logic [NB_ADDR-1:0] fault_addr_q, fault_addr_d;

  always_comb begin
    fault_d      = accept && misaligned;
    fault_addr_d = fault_addr_q;
    if (fault_d) begin
      fault_addr_d = i_addr;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;
`else
  assign o_fault      = 1'b0;
  assign o_fault_addr = '0;
`endif

endmodule

// File: tb/tb_store_formatter.sv
// Self-checking bench for store_formatter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the store path.
module tb_store_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush, i_valid, i_mem_ready;
  logic [31:0] i_addr, i_data;
  logic [1:0]  i_size;
  logic        o_ready, o_mem_valid, o_fault;
  logic [31:0] o_mem_addr, o_mem_wdata, o_fault_addr;
  logic [3:0]  o_mem_be;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [67:0] exp_q[$];
  logic        fault_pend;
  logic [31:0] mdl_fault_addr;
  logic        mdl_ready;

  store_formatter #(.NB_ADDR(32), .NB_DATA(32)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_data(i_data), .i_size(i_size), .o_mem_valid(o_mem_valid),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_be(o_mem_be), .o_fault(o_fault), .o_fault_addr(o_fault_addr),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference formatting from the store rules, using plain arithmetic.
  function automatic logic [67:0] ref_fmt(input logic [31:0] a, input logic [31:0] d,
                                          input logic [1:0] s);
    logic [31:0] wa, wd;
    logic [3:0]  be;
    int          lane;
    lane = int'(a % 4);
    wa   = a - (a % 4);
    if (s == 2'd0) begin
      wd = (d % 256) * 32'h0101_0101;
      be = 4'(1 << lane);
    end else if (s == 2'd1) begin
      wd = (d % 65536) * 32'h0001_0001;
      be = (lane >= 2) ? 4'd12 : 4'd3;
    end else begin
      wd = d;
      be = 4'd15;
    end
    return {wa, wd, be};
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] s);
`ifdef STORE_ALIGN_CHECK_EN
    if (s == 2'd3) return 1'b1;
    if (s == 2'd2) return (a % 4) != 0;
    if (s == 2'd1) return (a % 2) != 0;
    return 1'b0;
`else
    return (a == 32'hFFFF_FFFF) && (s == 2'd3) && 1'b0;
`endif
  endfunction

  // Scoreboard: model occupancy is the expected queue length; sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fault_pend     = 1'b0;
      mdl_fault_addr = '0;
    end else begin
      mdl_ready = (exp_q.size() < 2);
      checks++;
      if (o_ready !== mdl_ready) begin
        errors++; $display("FAIL sb_ready got %b exp %b at %0t", o_ready, mdl_ready, $time);
      end
      checks++;
      if (o_mem_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL sb_mem_valid got %b exp %b at %0t", o_mem_valid, exp_q.size() > 0, $time);
      end
      checks++;
      if (o_fault !== fault_pend || o_fault_addr !== mdl_fault_addr) begin
        errors++; $display("FAIL sb_fault got %b/%h exp %b/%h at %0t", o_fault, o_fault_addr,
                           fault_pend, mdl_fault_addr, $time);
      end
      if (exp_q.size() > 0 && o_mem_valid) begin
        checks++;
        if ({o_mem_addr, o_mem_wdata, o_mem_be} !== exp_q[0]) begin
          errors++; $display("FAIL sb_write got %h %h %b exp %h %h %b at %0t", o_mem_addr, o_mem_wdata,
                             o_mem_be, exp_q[0][67:36], exp_q[0][35:4], exp_q[0][3:0], $time);
        end
        if (i_mem_ready) void'(exp_q.pop_front());
      end
      fault_pend = 1'b0;
      if (i_flush) begin
        exp_q.delete();
      end else if (i_valid && mdl_ready) begin
        if (ref_misaligned(i_addr, i_size)) begin
          fault_pend     = 1'b1;
          mdl_fault_addr = i_addr;
        end else begin
          exp_q.push_back(ref_fmt(i_addr, i_data, i_size));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    i_valid = v; i_addr = a; i_data = d; i_size = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_mem_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0);
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1 || o_fault !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got valid=%b ready=%b fault=%b exp 0/1/0", o_mem_valid, o_ready, o_fault);
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_mem_be !== 4'h0 || o_fault_addr !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h %h %b %h exp zeros", o_mem_addr, o_mem_wdata, o_mem_be, o_fault_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_byte();
    i_mem_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'd0);
    step();
    drive(1'b0, '0, '0, 2'd0);
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h1000 || o_mem_wdata !== 32'hDDDD_DDDD || o_mem_be !== 4'b1000) begin
      errors++; $display("FAIL byte_store got v=%b %h %h %b exp 1 00001000 dddddddd 1000",
                         o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be);
    end
    step();
    checks++;
    if (o_mem_valid !== 1'b0) begin
      errors++; $display("FAIL byte_drain got %b exp 0", o_mem_valid);
    end
  endtask

  task automatic test_back_to_back();
    i_mem_ready = 1'b1;
    drive(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1);
    step();
    drive(1'b1, 32'h0000_2004, 32'h5566_7788, 2'd2);
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h2000 || o_mem_wdata !== 32'hBEEF_BEEF || o_mem_be !== 4'b1100) begin
      errors++; $display("FAIL half_store got v=%b %h %h %b exp 1 00002000 beefbeef 1100",
                         o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be);
    end
    step();
    drive(1'b0, '0, '0, 2'd0);
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h2004 || o_mem_wdata !== 32'h5566_7788 || o_mem_be !== 4'b1111) begin
      errors++; $display("FAIL word_b2b got v=%b %h %h %b exp 1 00002004 55667788 1111",
                         o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be);
    end
    step();
  endtask

  task automatic test_backpressure();
    i_mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'h0000_0011, 2'd0);
    step();
    drive(1'b1, 32'h0000_0204, 32'hCAFE_0001, 2'd2);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_one got %b exp 1", o_ready);
    end
    step();
    drive(1'b1, 32'h0000_0302, 32'h0000_ABCD, 2'd1);
    checks++;
    if (o_ready !== 1'b0 || o_mem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL bp_full got ready=%b addr=%h exp 0 00000100", o_ready, o_mem_addr);
    end
    step();
    checks++;
    if (o_ready !== 1'b0 || o_mem_addr !== 32'h0000_0100 || o_mem_be !== 4'b0001) begin
      errors++; $display("FAIL bp_hold got ready=%b addr=%h be=%b exp 0 00000100 0001", o_ready, o_mem_addr, o_mem_be);
    end
    i_mem_ready = 1'b1;
    step();
    checks++;
    if (o_ready !== 1'b1 || o_mem_addr !== 32'h0000_0204) begin
      errors++; $display("FAIL bp_second got ready=%b addr=%h exp 1 00000204", o_ready, o_mem_addr);
    end
    step();
    drive(1'b0, '0, '0, 2'd0);
    checks++;
    if (o_mem_addr !== 32'h0000_0300 || o_mem_wdata !== 32'hABCD_ABCD || o_mem_be !== 4'b1100) begin
      errors++; $display("FAIL bp_third got %h %h %b exp 00000300 abcdabcd 1100", o_mem_addr, o_mem_wdata, o_mem_be);
    end
    step();
  endtask

  task automatic test_flush();
    i_mem_ready = 1'b0;
    drive(1'b1, 32'h0000_4000, 32'h1, 2'd2);
    step();
    drive(1'b1, 32'h0000_4004, 32'h2, 2'd2);
    step();
    drive(1'b1, 32'h0000_4008, 32'h3, 2'd2);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b0, '0, '0, 2'd0);
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got valid=%b ready=%b exp 0 1", o_mem_valid, o_ready);
    end
    i_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_mem_valid !== 1'b0) begin
        errors++; $display("FAIL flush_quiet got %b exp 0", o_mem_valid);
      end
    end
  endtask

  task automatic test_misaligned();
    i_mem_ready = 1'b1;
    drive(1'b1, 32'h0000_3001, 32'hCAFE_F00D, 2'd2);
    step();
    drive(1'b0, '0, '0, 2'd0);
`ifdef STORE_ALIGN_CHECK_EN
    checks++;
    if (o_fault !== 1'b1 || o_fault_addr !== 32'h3001 || o_mem_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_fault got f=%b fa=%h v=%b exp 1 00003001 0", o_fault, o_fault_addr, o_mem_valid);
    end
    step();
    checks++;
    if (o_fault !== 1'b0 || o_fault_addr !== 32'h3001) begin
      errors++; $display("FAIL misalign_pulse got f=%b fa=%h exp 0 00003001", o_fault, o_fault_addr);
    end
`else
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h3000 || o_mem_be !== 4'b1111 || o_mem_wdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL misalign_word got v=%b %h %h %b exp 1 00003000 cafef00d 1111",
                         o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be);
    end
    step();
    checks++;
    if (o_fault !== 1'b0) begin
      errors++; $display("FAIL misalign_nofault got %b exp 0", o_fault);
    end
`endif
  endtask

  task automatic test_reset_stall();
    i_mem_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 32'h77, 2'd0);
    step();
    drive(1'b1, 32'h0000_5004, 32'h88, 2'd2);
    step();
    drive(1'b0, '0, '0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 ||
        o_mem_be !== 4'h0 || o_fault !== 1'b0 || o_fault_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset got v=%b r=%b %h %h %b exp 0 1 zeros", o_mem_valid, o_ready,
                         o_mem_addr, o_mem_wdata, o_mem_be);
    end
    @(negedge clk);
    step();
    rst_n = 1'b1;
    i_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_mem_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_write got %b exp 0", o_mem_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a % 64;
      drive(($urandom_range(0, 3) != 0), a, $urandom, 2'($urandom_range(0, 3)));
      i_mem_ready = ($urandom_range(0, 9) < 7);
      i_flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    drive(1'b0, '0, '0, 2'd0);
    i_flush = 1'b0;
    i_mem_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0 || o_mem_valid !== 1'b0) begin
      errors++; $display("FAIL random_drain got pending=%0d valid=%b exp 0 0", exp_q.size(), o_mem_valid);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_misaligned();
    test_reset_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_formatter.md
# store_formatter

Memory-side store formatter for the MIPS MEM stage: narrows 32-bit register data to byte/halfword/word stores. It replicates the value into the correct byte lanes, generates byte enables and word-aligns the address toward data memory. It is the write-direction counterpart of the immediate/load extension logic. Requests pass through a valid/ready handshake with a one-cycle output register and a one-entry skid buffer, so the memory can stall without losing stores.

## Interface
- NB_ADDR, 32, address width
- NB_DATA, 32, data width; only 32 is supported
- clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous drop of all buffered stores (pipeline flush)
- i_valid  input  1  store request valid
- o_ready  output  1  request can be accepted this cycle
- i_addr  input  NB_ADDR  byte address
- i_data  input  NB_DATA  register data (value in low bits)
- i_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- o_mem_valid  output  1  memory write valid
- i_mem_ready  input  1  memory accepts write
- o_mem_addr  output  NB_ADDR  {i_addr[NB_ADDR-1:2], 2'b00}
- o_mem_wdata  output  NB_DATA  lane-replicated data
- o_mem_be  output  4  byte enables, bit n = byte lane n
- o_fault  output  1  one-cycle misalignment pulse
- o_fault_addr  output  NB_ADDR  address of last faulting request

## Operation
- Accept when i_valid && o_ready && !i_flush.
- Formatting (little-endian, lane = addr[1:0]):
  - byte: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0]
  - half: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
  - word: wdata = data, be = 4'b1111
- Storage: output register (OUT) plus skid register (SKID). States:
  - EMPTY: accept loads OUT -> ONE.
  - ONE: accept with i_mem_ready loads OUT -> ONE. Accept without i_mem_ready loads SKID -> TWO. i_mem_ready alone -> EMPTY.
  - TWO: i_mem_ready moves SKID to OUT -> ONE; no accept possible.
- o_ready = (state != TWO), from registered state only; no combinational path from i_mem_ready.
- Flush: next state EMPTY and both registers invalidated. A same-cycle request is dropped, and no fault is raised for it. A write presented in the flush cycle still completes if i_mem_ready=1.
- Faulting requests are accepted, then discarded: no memory write and no state change except the fault outputs.

## Timing
- Reset (asynchronous, immediate): state EMPTY, o_ready=1, o_mem_valid=0, o_mem_addr/wdata/be=0, o_fault=0, o_fault_addr=0.
- Latency: accept at edge N -> o_mem_valid high after edge N. One store per cycle when i_mem_ready is held 1.
- o_mem_* stable while o_mem_valid && !i_mem_ready; stores leave in acceptance order.
- o_fault is high exactly the cycle after a faulting accept. o_fault_addr updates at the same edge and holds until the next fault.
- Reset during a stall discards both buffered stores; no write is issued after release.

## Configuration
- STORE_ALIGN_CHECK_EN defined: a fault is raised on half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- STORE_ALIGN_CHECK_EN undefined:
  - No checks; o_fault and o_fault_addr are tied 0.
  - Half uses addr[1] only; word ignores addr[1:0].
  - Size 11 is formatted as a word.

## Test plan
- Byte store: addr 0x1003, data 0xAABBCCDD, size 00, mem ready -> next cycle o_mem_addr 0x1000, wdata 0xDDDDDDDD, be 1000.
- Half store: addr 0x2002, data 0x1234BEEF, size 01 -> wdata 0xBEEFBEEF, be 1100. Word store to 0x2004 on the following cycle -> be 1111, back-to-back valid.
- Backpressure: i_mem_ready=0, issue 3 stores -> first two held (o_ready falls after the second). Release -> written in order; third accepted only after o_ready returns.
- Flush in TWO with i_valid=1 -> o_mem_valid=0 next cycle, o_ready=1, nothing further written.
- With STORE_ALIGN_CHECK_EN: word at 0x3001 -> o_fault one cycle, o_fault_addr 0x3001, no write. Without the macro -> write to 0x3000, be 1111.
- Assert i_rst_n=0 mid-stall -> all outputs at reset values immediately; no write after release.
